// File: rtl/genius_pkg.sv
// Shared types and defaults for the color-sequence memory game.
package genius_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQUEST = 3'd1,
        ST_SHOW    = 3'd2,
        ST_GAP     = 3'd3,
        ST_INPUT   = 3'd4,
        ST_WIN     = 3'd5,
        ST_FAIL    = 3'd6
    } state_e;

    typedef logic [1:0] color_t;

    localparam int MAX_LEN     = 16;
    localparam int SHOW_CYCLES = 4;

    function automatic logic [3:0] color_onehot(input color_t c);
        return 4'b0001 << c;
    endfunction

    function automatic logic is_onehot(input logic [3:0] v);
        return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
    endfunction

endpackage

// File: rtl/show_timer.sv
// Loadable down-counter; o_tc flags the last cycle of a SHOW or GAP interval.
module show_timer #(
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_tc
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_tc = (count_q == WIDTH'(1));

endmodule

// File: rtl/sequence_checker_module.sv
// Color-sequence memory game: grows a sequence one color per round, plays it
// back on the LEDs, then checks the player's presses against it.
//   state   | meaning
//   IDLE    | waiting for i_start after reset
//   REQUEST | asking the generator for the next color
//   SHOW    | lighting mem[index]
//   GAP     | blank pause after each shown color
//   INPUT   | comparing presses against mem[index]
//   WIN     | full MAX_LEN sequence repeated correctly
//   FAIL    | wrong or multi-button press
module sequence_checker_module
    import genius_pkg::*;
#(
    parameter int MAX_LEN     = genius_pkg::MAX_LEN,
    parameter int SHOW_CYCLES = genius_pkg::SHOW_CYCLES
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_start,
    output logic                           o_gen_trigger,
    input  logic                           i_gen_done,
    input  logic [1:0]                     i_gen_value,
    input  logic [3:0]                     i_button,
    output logic [3:0]                     o_led,
    output logic [$clog2(MAX_LEN+1)-1:0]   o_length,
    output logic [2:0]                     o_state,
    output logic                           o_win,
    output logic                           o_fail
);

    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int IDX_W = (MAX_LEN > 2) ? $clog2(MAX_LEN) : 1;
    localparam int CNT_W = $clog2(SHOW_CYCLES + 1);

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   length_q, length_d;
    logic [IDX_W-1:0]   index_q, index_d;
    logic               trig_q, trig_d;
    logic [3:0]         led_q, led_d;
    color_t             mem_q [MAX_LEN];

    logic               mem_we;
    logic               last_idx;
    color_t             cur_color;
    color_t             shown_color;
    logic               timer_load;
    logic               timer_tc;

    assign last_idx  = (LEN_W'(index_q) == (length_q - LEN_W'(1)));
    assign cur_color = mem_q[index_q];

    always_comb begin
        state_d  = state_q;
        length_d = length_q;
        index_d  = index_q;
        mem_we   = 1'b0;

        case (state_q)
            ST_IDLE, ST_WIN, ST_FAIL: begin
                if (i_start) begin
                    state_d  = ST_REQUEST;
                    length_d = '0;
                    index_d  = '0;
                end
            end
            ST_REQUEST: begin
                if (i_gen_done) begin
                    mem_we   = 1'b1;
                    length_d = length_q + LEN_W'(1);
                    index_d  = '0;
                    state_d  = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (timer_tc) begin
                    state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                if (timer_tc) begin
                    if (last_idx) begin
                        state_d = ST_INPUT;
                        index_d = '0;
                    end else begin
                        state_d = ST_SHOW;
                        index_d = index_q + IDX_W'(1);
                    end
                end
            end
            ST_INPUT: begin
                // i_start is deliberately not looked at here
                if (i_button != 4'b0000) begin
                    if (is_onehot(i_button) && (i_button == color_onehot(cur_color))) begin
                        if (last_idx) begin
                            state_d = (length_q == LEN_W'(MAX_LEN)) ? ST_WIN : ST_REQUEST;
                        end else begin
                            index_d = index_q + IDX_W'(1);
                        end
                    end else begin
                        state_d = ST_FAIL;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The color being written this edge is not in mem_q yet; bypass it.
        if (mem_we && (index_d == length_q[IDX_W-1:0])) begin
            shown_color = i_gen_value;
        end else begin
            shown_color = mem_q[index_d];
        end

        trig_d     = (state_d == ST_REQUEST);
        led_d      = (state_d == ST_SHOW) ? color_onehot(shown_color) : 4'b0000;
        timer_load = ((state_d == ST_SHOW) || (state_d == ST_GAP)) && (state_d != state_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            length_q <= '0;
            index_q  <= '0;
            trig_q   <= 1'b0;
            led_q    <= 4'b0000;
        end else begin
            state_q  <= state_d;
            length_q <= length_d;
            index_q  <= index_d;
            trig_q   <= trig_d;
            led_q    <= led_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (mem_we && !i_rst) begin
            mem_q[length_q[IDX_W-1:0]] <= i_gen_value;
        end
    end

    show_timer #(
        .WIDTH (CNT_W)
    ) u_show_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_load     (timer_load),
        .i_load_val (CNT_W'(SHOW_CYCLES)),
        .o_tc       (timer_tc)
    );

    assign o_gen_trigger = trig_q;
    assign o_led         = led_q;
    assign o_length      = length_q;
    assign o_state       = state_q;
    assign o_win         = (state_q == ST_WIN);
    assign o_fail        = (state_q == ST_FAIL);

endmodule

// File: tb/tb_sequence_checker_module.sv
// Bench for sequence_checker_module with MAX_LEN=3, SHOW_CYCLES=2, checked against a queue-based game model.
module tb_sequence_checker_module;

    localparam int ML = 3;
    localparam int SC = 2;
    localparam int LW = $clog2(ML + 1);

    localparam int M_IDLE  = 0;
    localparam int M_REQ   = 1;
    localparam int M_SHOW  = 2;
    localparam int M_GAP   = 3;
    localparam int M_INPUT = 4;
    localparam int M_WIN   = 5;
    localparam int M_LOST  = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          gen_done = 1'b0;
    logic [1:0]    gen_value = 2'd0;
    logic [3:0]    button = 4'd0;
    logic          trig;
    logic [3:0]    led;
    logic [LW-1:0] length;
    logic [2:0]    state;
    logic          win;
    logic          fail;

    int n_checks = 0;
    int n_fail   = 0;
    int seq[$];
    int exp_idx  = 0;
    int m_state  = M_IDLE;

    always #5 clk = ~clk;

    sequence_checker_module #(
        .MAX_LEN     (ML),
        .SHOW_CYCLES (SC)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .o_gen_trigger (trig),
        .i_gen_done    (gen_done),
        .i_gen_value   (gen_value),
        .i_button      (button),
        .o_led         (led),
        .o_length      (length),
        .o_state       (state),
        .o_win         (win),
        .o_fail        (fail)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outputs(input string tag);
        chk({tag, ".state"}, 32'(state), m_state);
        chk({tag, ".length"}, 32'(length), seq.size());
        chk({tag, ".trig"}, 32'(trig), (m_state == M_REQ) ? 1 : 0);
        chk({tag, ".win"}, 32'(win), (m_state == M_WIN) ? 1 : 0);
        chk({tag, ".fail"}, 32'(fail), (m_state == M_LOST) ? 1 : 0);
        chk({tag, ".led"}, 32'(led), 0);
    endtask

    task automatic start_game();
        start = 1'b1;
        step();
        start = 1'b0;
        if (m_state == M_IDLE || m_state == M_WIN || m_state == M_LOST) begin
            seq.delete();
            exp_idx = 0;
            m_state = M_REQ;
        end
        chk_outputs("start");
    endtask

    task automatic do_round(input int v, input int delay, input bit noise);
        logic [3:0] want;
        for (int d = 0; d < delay; d++) begin
            step();
            chk("trig_hold", 32'(trig), 1);
        end
        gen_done  = 1'b1;
        gen_value = 2'(v);
        step();
        gen_done  = 1'b0;
        gen_value = 2'($urandom_range(0, 3));
        seq.push_back(v);
        m_state = M_SHOW;
        for (int i = 0; i < seq.size(); i++) begin
            want = 4'b0001 << seq[i];
            for (int c = 0; c < SC; c++) begin
                chk("show_led", 32'(led), 32'(want));
                chk("show_state", 32'(state), M_SHOW);
                if (noise && i == 0 && c == 0) begin
                    gen_done  = 1'b1;
                    gen_value = 2'($urandom_range(0, 3));
                    button    = 4'($urandom_range(1, 15));
                    start     = 1'b1;
                end
                step();
                gen_done = 1'b0;
                button   = 4'd0;
                start    = 1'b0;
            end
            for (int c = 0; c < SC; c++) begin
                chk("gap_led", 32'(led), 0);
                chk("gap_state", 32'(state), M_GAP);
                step();
            end
        end
        m_state = M_INPUT;
        exp_idx = 0;
        chk_outputs("input_entry");
    endtask

    task automatic press(input logic [3:0] btn, input bit with_start);
        logic [3:0] want;
        want   = 4'b0001 << seq[exp_idx];
        button = btn;
        start  = with_start;
        step();
        button = 4'd0;
        start  = 1'b0;
        if (btn != 4'd0) begin
            if (btn == want) begin
                if (exp_idx == seq.size() - 1) begin
                    m_state = (seq.size() == ML) ? M_WIN : M_REQ;
                end else begin
                    exp_idx++;
                end
            end else begin
                m_state = M_LOST;
            end
        end
        chk_outputs("press");
    endtask

    task automatic play_correct();
        logic [3:0] want;
        int guard;
        guard = 0;
        while (m_state == M_INPUT && guard < 20) begin
            want = 4'b0001 << seq[exp_idx];
            press(want, 1'b0);
            guard++;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] btn;
        int r;
        int guard;

        // reset held and released
        rst = 1'b1;
        step();
        step();
        seq.delete();
        m_state = M_IDLE;
        chk_outputs("reset_hold");
        rst = 1'b0;
        repeat (3) step();
        chk_outputs("idle_after_reset");

        // first round with color 2, then second round color 0
        start_game();
        do_round(2, 3, 1'b0);
        press(4'b0100, 1'b0);
        do_round(0, 0, 1'b0);
        press(4'b0100, 1'b0);
        press(4'b0001, 1'b0);
        do_round($urandom_range(0, 3), 1, 1'b1);
        play_correct();
        chk("game1_win", 32'(state), M_WIN);

        // full game 1,3,0
        start_game();
        do_round(1, 0, 1'b0);
        play_correct();
        do_round(3, 2, 1'b1);
        play_correct();
        do_round(0, 1, 1'b0);
        play_correct();
        repeat (4) begin
            step();
            chk_outputs("win_hold");
        end

        // wrong one-hot press against expected color 3
        start_game();
        do_round(3, 1, 1'b0);
        press(4'b0010, 1'b0);

        // restart from lost game, then a two-button press
        start_game();
        do_round($urandom_range(0, 3), 0, 1'b0);
        press(4'b0011, 1'b0);

        // i_start ignored in INPUT, alone and together with a press
        start_game();
        do_round($urandom_range(0, 3), 0, 1'b0);
        play_correct();
        do_round($urandom_range(0, 3), 0, 1'b0);
        start = 1'b1;
        step();
        start = 1'b0;
        chk_outputs("start_in_input");
        btn = 4'b0001 << seq[exp_idx];
        press(btn, 1'b1);
        btn = 4'b0001 << seq[exp_idx];
        press(btn, 1'b1);

        // i_start ignored in REQUEST, then reset during GAP with a done pulse
        start = 1'b1;
        step();
        start = 1'b0;
        chk_outputs("start_in_request");
        gen_done  = 1'b1;
        gen_value = 2'd1;
        step();
        gen_done = 1'b0;
        repeat (SC) step();
        chk("gap_before_reset", 32'(state), M_GAP);
        rst      = 1'b1;
        gen_done = 1'b1;
        step();
        seq.delete();
        m_state = M_IDLE;
        chk_outputs("reset_in_gap");
        rst      = 1'b0;
        gen_done = 1'b0;
        repeat (2) step();
        chk_outputs("idle_post_reset");

        // randomized games
        for (int g = 0; g < 8; g++) begin
            start_game();
            guard = 0;
            while (m_state != M_WIN && m_state != M_LOST && guard < 200) begin
                do_round($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
                while (m_state == M_INPUT && guard < 200) begin
                    r = $urandom_range(0, 15);
                    if (r == 0) begin
                        btn = 4'($urandom_range(1, 15));
                    end else if (r < 3) begin
                        btn = 4'd0;
                    end else begin
                        btn = 4'b0001 << seq[exp_idx];
                    end
                    press(btn, 1'($urandom_range(0, 1)));
                    guard++;
                end
                guard++;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sequence_checker_module.md
SEQUENCE_CHECKER_MODULE -- requirements
Module: sequence_checker_module

Interface
REQ-001 MAX_LEN, 16, maximum sequence length; reaching it wins the game.
REQ-002 SHOW_CYCLES, 4, cycles each color is lit during playback; the blank gap is the same length.
REQ-003 i_clk  input  1  system clock; single clock domain.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_start  input  1  one-cycle pulse; starts a new game from IDLE, WIN or FAIL.
REQ-006 o_gen_trigger  output  1  request to the generator; held high until i_gen_done.
REQ-007 i_gen_done  input  1  one-cycle generator completion pulse.
REQ-008 i_gen_value  input  2  color code 0-3; valid only while i_gen_done=1.
REQ-009 i_button  input  4  player press; one-cycle, already debounced; bit n = color n.
REQ-010 o_led  output  4  one-hot color display; 0 outside SHOW.
REQ-011 o_length  output  $clog2(MAX_LEN+1)  current sequence length.
REQ-012 o_state  output  3  current FSM state code.
REQ-013 o_win  output  1  high while in WIN.
REQ-014 o_fail  output  1  high while in FAIL.

Function
REQ-015 FSM states and codes: IDLE=0, REQUEST=1, SHOW=2, GAP=3, INPUT=4, WIN=5, FAIL=6.
REQ-016 IDLE/WIN/FAIL + i_start -> REQUEST, with length:=0 and index:=0.
REQ-017 REQUEST: o_gen_trigger=1.
- On i_gen_done: mem[length]:=i_gen_value, length:=length+1, index:=0, go to SHOW.
REQ-018 i_gen_done outside REQUEST is ignored; it does not write memory.
REQ-019 SHOW: o_led=onehot(mem[index]) for exactly SHOW_CYCLES cycles, then GAP.
REQ-020 GAP: o_led=0 for exactly SHOW_CYCLES cycles.
- Then, if index==length-1: go to INPUT with index:=0.
- Otherwise: index:=index+1 and go to SHOW.
REQ-021 INPUT: i_button==0 holds the state; there is no timeout.
REQ-022 INPUT: a non-one-hot i_button, or a one-hot press not equal to onehot(mem[index]), goes to FAIL.
REQ-023 INPUT: a matching press with index<length-1 sets index:=index+1 and stays in INPUT.
REQ-024 INPUT: a matching press with index==length-1 goes to WIN if length==MAX_LEN, otherwise to REQUEST.
REQ-025 A press is evaluated on the sampling edge; the resulting state is visible on o_state the next cycle.
REQ-026 i_button is ignored outside INPUT.
REQ-027 i_start is ignored in REQUEST, SHOW, GAP and INPUT.
- When i_start and i_button coincide in INPUT, the button is processed and i_start is dropped.
REQ-028 Memory is MAX_LEN x 2-bit registers, not reset; entries at or above length are never read.
REQ-029 The show counter reloads on every SHOW/GAP entry and counts down to 1, with no drift across rounds.
REQ-030 All outputs are registered except o_win and o_fail, which are decoded from the state register.

Reset
REQ-031 While i_rst=1:
- state=IDLE; length, index and the show counter = 0.
- o_gen_trigger=0, o_led=0, o_win=0, o_fail=0.
REQ-032 Reset mid-game aborts on the next edge, and any i_gen_done in the same cycle is discarded.
REQ-033 After reset deasserts, the block stays in IDLE until i_start.

Structure
REQ-034 Shared package genius_pkg holds:
- the state enum with the codes of REQ-015;
- color_t (2-bit);
- default constants MAX_LEN=16 and SHOW_CYCLES=4.
REQ-035 One sub-module, show_timer (loadable down-counter with a terminal-count pulse), serves both SHOW and GAP.

Verification (MAX_LEN=3, SHOW_CYCLES=2)
REQ-036 Reset, i_start, generator returns 2 -> o_gen_trigger high until done; o_led=0100 for 2 cycles, 0 for 2 cycles; INPUT with o_length=1.
REQ-037 Round 1 value 2, press 0100; round 2 value 0 -> playback order 0100 then 0001; presses 0100, 0001 -> REQUEST with o_length=2.
REQ-038 Full game with values 1,3,0 and correct presses -> o_state=WIN, o_win=1, o_length=3, no further trigger.
REQ-039 In INPUT expecting color 3, press 0010 -> FAIL with o_fail=1; also press 0011 -> FAIL.
REQ-040 i_gen_done pulse during SHOW -> ignored, memory unchanged; i_rst asserted in GAP -> IDLE with all outputs 0 next cycle.
REQ-041 FAIL, then i_start -> REQUEST with o_length=0, then 1 after done; o_fail=0.
